// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packet FIFO.
//   cnt_w(depth) : bit width needed to hold a value in 0..depth
//   fifo_mode_e  : cut-through or store-and-forward operation
package stream_pkg;

    typedef enum logic {
        CUT_THROUGH = 1'b0,
        STORE_FWD   = 1'b1
    } fifo_mode_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/stream_pkt_fifo_if.sv
// Valid/ready beat stream carrying data plus end-of-packet.
//   data  : beat payload
//   last  : end-of-packet marker
//   valid : beat offered by the master
//   ready : beat accepted by the slave
interface stream_pkt_fifo_if #(
    parameter int unsigned T_DATA_WIDTH = 32
) ();

    logic [T_DATA_WIDTH-1:0] data;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);

endinterface

// File: rtl/stream_fifo_ram.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write word
//   raddr : read address,  rdata : read word (combinational)
// Storage is intentionally not reset; occupancy is tracked by the owner.
module stream_fifo_ram #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_pkt_fifo.sv
// Stream FIFO carrying data+last with optional store-and-forward on packet boundaries.
//   clk, rst  : clock, synchronous active-high reset
//   s_if      : input beat stream (slave side)
//   m_if      : output beat stream (master side), head read straight from storage
//   count     : beats stored
//   pkt_count : complete packets stored (last beats held)
// In STORE_FWD mode the head is only offered once a whole packet is held, or when the
// FIFO is full (so an oversize packet cannot deadlock); after such a release the rest of
// that packet streams through until its last beat is popped.
module stream_pkt_fifo
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 32,
    parameter int unsigned DEPTH        = 8,
    parameter fifo_mode_e  PKT_MODE     = CUT_THROUGH
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_pkt_fifo_if.slave         s_if,
    stream_pkt_fifo_if.master        m_if,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic [cnt_w(DEPTH)-1:0]  pkt_count
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned RAM_W = T_DATA_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             rel_q, rel_d;

    logic             full;
    logic             empty;
    logic             s_ready_c;
    logic             m_valid_c;
    logic             push;
    logic             pop;
    logic             head_last;
    logic [RAM_W-1:0] rd_word;

    // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    stream_fifo_ram #(
        .WIDTH (RAM_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({s_if.last, s_if.data}),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_last = rd_word[T_DATA_WIDTH];

    // No pass-through when full: a same-cycle pop does not open the input.
    assign s_ready_c = !rst && !full;

    // Head availability; rel_q holds the output open for the tail of a released packet.
    always_comb begin
        m_valid_c = 1'b0;
        if (PKT_MODE == STORE_FWD) begin
            m_valid_c = !rst && !empty && ((pkt_count_q != '0) || full || rel_q);
        end else begin
            m_valid_c = !rst && !empty;
        end
    end

    assign push = s_if.valid && s_ready_c;
    assign pop  = m_valid_c && m_if.ready;

    assign s_if.ready = s_ready_c;
    assign m_if.valid = m_valid_c;
    assign m_if.data  = rd_word[T_DATA_WIDTH-1:0];
    assign m_if.last  = head_last;
    assign count      = count_q;
    assign pkt_count  = pkt_count_q;

    // Next-state for pointers, counters and the release flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rel_d       = rel_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        pkt_count_d = pkt_count_q + CNT_W'(push && s_if.last) - CNT_W'(pop && head_last);
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            // Popping a non-last beat means the rest of its packet must keep flowing.
            rel_d    = !head_last;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            rel_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            rel_q       <= rel_d;
        end
    end

    // Occupancy sanity and source protocol checks
    a_count_max : assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_pkt_le_count : assert property (@(posedge clk) disable iff (rst)
        pkt_count_q <= count_q);
    a_s_stable : assert property (@(posedge clk) disable iff (rst)
        (s_if.valid && !s_ready_c) |=>
            (!s_if.valid || ($stable(s_if.data) && $stable(s_if.last))));

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Bench for stream_pkt_fifo: a cut-through and a store-and-forward instance share the
// same stimulus; a queue model of each is compared against the DUT every cycle, and
// hand-derived literal checks pin the expected behaviour along the directed sequence.
module tb_stream_pkt_fifo;
    import stream_pkg::*;

    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int          DEPTH_I = 4;
    localparam int unsigned CW      = cnt_w(DEPTH);

    typedef logic [DW:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_valid;
    logic          m_ready;
    logic [CW-1:0] cnt_ct, pkt_ct, cnt_sf, pkt_sf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_pkt_fifo_if #(.T_DATA_WIDTH(DW)) s_ct ();
    stream_pkt_fifo_if #(.T_DATA_WIDTH(DW)) m_ct ();
    stream_pkt_fifo_if #(.T_DATA_WIDTH(DW)) s_sf ();
    stream_pkt_fifo_if #(.T_DATA_WIDTH(DW)) m_sf ();

    assign s_ct.data  = s_data;
    assign s_ct.last  = s_last;
    assign s_ct.valid = s_valid;
    assign m_ct.ready = m_ready;
    assign s_sf.data  = s_data;
    assign s_sf.last  = s_last;
    assign s_sf.valid = s_valid;
    assign m_sf.ready = m_ready;

    stream_pkt_fifo #(.T_DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(CUT_THROUGH)) dut_ct (
        .clk(clk), .rst(rst), .s_if(s_ct), .m_if(m_ct), .count(cnt_ct), .pkt_count(pkt_ct));

    stream_pkt_fifo #(.T_DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(STORE_FWD)) dut_sf (
        .clk(clk), .rst(rst), .s_if(s_sf), .m_if(m_sf), .count(cnt_sf), .pkt_count(pkt_sf));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    beat_t q_ct[$];
    beat_t q_sf[$];
    bit    mid_sf = 1'b0;
    bit    chk_en = 1'b0;

    function automatic int exp_pkts(input beat_t q[$]);
        int n = 0;
        foreach (q[i]) if (q[i][DW]) n++;
        return n;
    endfunction

    // Head offered: anything stored (cut-through); in store-and-forward a whole packet
    // stored, a full FIFO, or the tail of a packet already partly sent.
    function automatic bit exp_valid(input beat_t q[$], input bit sf, input bit mid, input logic r);
        if (r || q.size() == 0) return 1'b0;
        if (!sf) return 1'b1;
        return (exp_pkts(q) != 0) || (q.size() == DEPTH_I) || mid;
    endfunction

    initial begin : model
        bit    v_ct, v_sf, r_ct, r_sf;
        beat_t b;
        forever begin
            @(posedge clk);
            v_ct = exp_valid(q_ct, 1'b0, 1'b0, rst);
            v_sf = exp_valid(q_sf, 1'b1, mid_sf, rst);
            r_ct = !rst && (q_ct.size() < DEPTH_I);
            r_sf = !rst && (q_sf.size() < DEPTH_I);
            if (rst) begin
                q_ct.delete();
                q_sf.delete();
                mid_sf = 1'b0;
                chk_en = 1'b1;
            end else begin
                if (m_ready && v_ct) b = q_ct.pop_front();
                if (m_ready && v_sf) begin
                    b      = q_sf.pop_front();
                    mid_sf = !b[DW];
                end
                if (s_valid && r_ct) q_ct.push_back({s_last, s_data});
                if (s_valid && r_sf) q_sf.push_back({s_last, s_data});
            end
        end
    end

    task automatic cmp(input string tag, input logic a_rdy, input logic a_vld,
                       input logic [DW-1:0] a_d, input logic a_l,
                       input logic [CW-1:0] a_c, input logic [CW-1:0] a_p,
                       input beat_t q[$], input bit sf, input bit mid);
        bit    ev;
        beat_t h;
        ev = exp_valid(q, sf, mid, rst);
        check({tag, ".s_ready"}, 64'(a_rdy), 64'(!rst && (q.size() < DEPTH_I)));
        check({tag, ".m_valid"}, 64'(a_vld), 64'(ev));
        if (ev) begin
            h = q[0];
            check({tag, ".m_data"}, 64'(a_d), 64'(h[DW-1:0]));
            check({tag, ".m_last"}, 64'(a_l), 64'(h[DW]));
        end
        check({tag, ".count"}, 64'(a_c), 64'(q.size()));
        check({tag, ".pkt_count"}, 64'(a_p), 64'(exp_pkts(q)));
    endtask

    // Every-cycle comparison on the falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp("ct", s_ct.ready, m_ct.valid, m_ct.data, m_ct.last, cnt_ct, pkt_ct, q_ct, 1'b0, 1'b0);
                cmp("sf", s_sf.ready, m_sf.valid, m_sf.data, m_sf.last, cnt_sf, pkt_sf, q_sf, 1'b1, mid_sf);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    initial begin : stim
        // 1. reset with s_valid held high
        rst     = 1'b1;
        m_ready = 1'b0;
        drive(1'b1, 32'h55, 1'b1);
        repeat (3) begin
            step();
            check("t1.rst_s_ready", 64'(s_ct.ready), 64'(0));
            check("t1.rst_m_valid", 64'(m_sf.valid), 64'(0));
            check("t1.rst_count", 64'(cnt_ct), 64'(0));
        end
        rst = 1'b0;
        step();
        check("t1.first_push_count", 64'(cnt_ct), 64'(1));
        check("t1.first_push_data", 64'(m_ct.data), 64'h55);
        check("t1.first_push_pkt_sf", 64'(pkt_sf), 64'(1));
        drive(1'b0, '0, 1'b0);
        m_ready = 1'b1;
        step();
        check("t1.drained_sf", 64'(cnt_sf), 64'(0));

        // 2. cut-through 1,2,3(last)
        drive(1'b1, 32'h1, 1'b0); step();
        check("t2.ct_valid", 64'(m_ct.valid), 64'(1));
        check("t2.ct_data1", 64'(m_ct.data), 64'h1);
        check("t2.sf_hold", 64'(m_sf.valid), 64'(0));
        drive(1'b1, 32'h2, 1'b0); step();
        check("t2.ct_data2", 64'(m_ct.data), 64'h2);
        check("t2.ct_count", 64'(cnt_ct), 64'(1));
        drive(1'b1, 32'h3, 1'b1); step();
        check("t2.ct_data3", 64'(m_ct.data), 64'h3);
        check("t2.ct_last3", 64'(m_ct.last), 64'(1));
        drive(1'b0, '0, 1'b0); step();
        check("t2.ct_empty", 64'(cnt_ct), 64'(0));
        repeat (3) step();

        // 3. full / backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'hA + i), 1'b0);
            step();
        end
        drive(1'b1, 32'hE, 1'b1); step();
        check("t3.full_s_ready", 64'(s_ct.ready), 64'(0));
        check("t3.full_count", 64'(cnt_ct), 64'(4));
        check("t3.sf_override", 64'(m_sf.valid), 64'(1));
        check("t3.sf_head", 64'(m_sf.data), 64'hA);
        m_ready = 1'b1;
        step();
        check("t3.pop_a_count", 64'(cnt_ct), 64'(3));
        check("t3.head_b", 64'(m_ct.data), 64'hB);
        step();
        check("t3.e_accepted_count", 64'(cnt_ct), 64'(3));
        check("t3.head_c", 64'(m_sf.data), 64'hC);
        drive(1'b0, '0, 1'b0); step();
        check("t3.head_d", 64'(m_ct.data), 64'hD);
        step();
        check("t3.head_e", 64'(m_sf.data), 64'hE);
        check("t3.head_e_last", 64'(m_sf.last), 64'(1));
        step();
        check("t3.empty", 64'(cnt_sf), 64'(0));

        // 4. store-and-forward: 41,42,43(last)
        drive(1'b1, 32'h41, 1'b0); step();
        drive(1'b1, 32'h42, 1'b0); step();
        check("t4.sf_hold", 64'(m_sf.valid), 64'(0));
        check("t4.sf_count2", 64'(cnt_sf), 64'(2));
        drive(1'b1, 32'h43, 1'b1); step();
        check("t4.sf_release", 64'(m_sf.valid), 64'(1));
        check("t4.sf_pkt", 64'(pkt_sf), 64'(1));
        check("t4.sf_head41", 64'(m_sf.data), 64'h41);
        drive(1'b0, '0, 1'b0); step();
        check("t4.sf_head42", 64'(m_sf.data), 64'h42);
        step();
        check("t4.sf_head43", 64'(m_sf.data), 64'h43);
        step();
        check("t4.sf_empty", 64'(cnt_sf), 64'(0));

        // 5. oversize packet 61..66, last on 66
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'h61 + i), 1'b0);
            step();
        end
        check("t5.sf_full", 64'(cnt_sf), 64'(4));
        check("t5.sf_override", 64'(m_sf.valid), 64'(1));
        check("t5.sf_head61", 64'(m_sf.data), 64'h61);
        drive(1'b1, 32'h65, 1'b0); step();
        check("t5.sf_head62", 64'(m_sf.data), 64'h62);
        check("t5.sf_count3", 64'(cnt_sf), 64'(3));
        step();
        check("t5.sf_head63", 64'(m_sf.data), 64'h63);
        drive(1'b1, 32'h66, 1'b1); step();
        check("t5.sf_head64", 64'(m_sf.data), 64'h64);
        check("t5.sf_pkt1", 64'(pkt_sf), 64'(1));
        drive(1'b0, '0, 1'b0); step();
        check("t5.sf_head65", 64'(m_sf.data), 64'h65);
        step();
        check("t5.sf_head66", 64'(m_sf.data), 64'h66);
        check("t5.sf_last66", 64'(m_sf.last), 64'(1));
        step();
        check("t5.sf_pkt0", 64'(pkt_sf), 64'(0));
        check("t5.sf_count0", 64'(cnt_sf), 64'(0));

        // 6. mid-operation reset with 3 beats stored
        m_ready = 1'b0;
        drive(1'b1, 32'h71, 1'b0); step();
        drive(1'b1, 32'h72, 1'b0); step();
        drive(1'b1, 32'h73, 1'b1); step();
        check("t6.pre_count", 64'(cnt_sf), 64'(3));
        check("t6.pre_pkt", 64'(pkt_sf), 64'(1));
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6.post_count", 64'(cnt_sf), 64'(0));
        check("t6.post_pkt", 64'(pkt_sf), 64'(0));
        check("t6.post_valid_ct", 64'(m_ct.valid), 64'(0));
        check("t6.post_valid_sf", 64'(m_sf.valid), 64'(0));
        m_ready = 1'b1;
        drive(1'b1, 32'h81, 1'b1); step();
        check("t6.new_ct", 64'(m_ct.data), 64'h81);
        check("t6.new_sf", 64'(m_sf.data), 64'h81);
        drive(1'b0, '0, 1'b0); step();
        check("t6.final_empty", 64'(cnt_ct), 64'(0));
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
